// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Brief    : Shared constants and types for the LED fade/PWM output stage.
// Revision : 1.0
// ============================================================================
package led_pkg;

    localparam int NUM_LEDS     = 8;
    localparam int PWM_BITS_DEF = 8;
    localparam int PRESCALE_DEF = 64;
    localparam int FADE_DIV_DEF = 4;
    localparam int DECAY_DEF    = 16;

    typedef logic [PWM_BITS_DEF-1:0] intensity_t;

    // Counter width that never collapses to zero bits for a modulus of 1.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_channel
// Brief    : One LED: intensity register with load/saturating decay and the
//            registered PWM compare output.
// Revision : 1.0
// ============================================================================
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int DECAY    = DECAY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                decay_step,
    input  logic                pattern_bit,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                enable,
    output logic                led_out
);

    // A decay larger than full scale behaves the same as full scale: it
    // always saturates to zero, so clamp it to keep the subtraction in range.
    localparam int c_LEVEL_MAX = (1 << PWM_BITS) - 1;
    localparam int c_DECAY_SAT = (DECAY > c_LEVEL_MAX) ? c_LEVEL_MAX : DECAY;
    localparam logic [PWM_BITS-1:0] c_DECAY = c_DECAY_SAT[PWM_BITS-1:0];

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_level_nxt;
    logic                r_led;

    always_comb begin
        w_level_nxt = r_level;
        if (frame_tick) begin
            if (pattern_bit) begin
                w_level_nxt = brightness;
            end else if (decay_step) begin
                w_level_nxt = (r_level < c_DECAY) ? '0 : (r_level - c_DECAY);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            r_led   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_led   <= enable && (pwm_cnt < r_level);
        end
    end

    assign led_out = r_led;

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_fade_pwm
// Brief    : Per-LED PWM driver with global brightness and fade-out trails
//            for the rotating LED pattern.
// Revision : 1.0
// ============================================================================
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF,
    parameter int DECAY    = DECAY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                frame_tick
);

    localparam int c_PRESC_W = cnt_width(PRESCALE);
    localparam int c_FADE_W  = cnt_width(FADE_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);
    localparam logic [c_FADE_W-1:0]  c_FADE_MAX  = c_FADE_W'(FADE_DIV - 1);

    logic [c_PRESC_W-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [c_FADE_W-1:0]  r_fade_cnt;
    logic                 w_presc_wrap;
    logic                 w_frame_tick;
    logic                 w_decay_step;

    assign w_presc_wrap = (r_presc == c_PRESC_MAX);
    assign w_frame_tick = w_presc_wrap && (r_pwm_cnt == '1);
    assign w_decay_step = w_frame_tick && (r_fade_cnt == c_FADE_MAX);
    assign frame_tick   = w_frame_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_pwm_cnt  <= '0;
            r_fade_cnt <= '0;
        end else begin
            if (w_presc_wrap) begin
                r_presc   <= '0;
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_frame_tick) begin
                r_fade_cnt <= (r_fade_cnt == c_FADE_MAX) ? '0 : (r_fade_cnt + 1'b1);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS),
            .DECAY    (DECAY)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .frame_tick  (w_frame_tick),
            .decay_step  (w_decay_step),
            .pattern_bit (pattern[gi]),
            .brightness  (brightness),
            .pwm_cnt     (r_pwm_cnt),
            .enable      (enable),
            .led_out     (led_out[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fade_pwm
// Brief    : Directed self-checking bench for led_fade_pwm (32-clock frames).
// Revision : 1.0
// ============================================================================
module tb_led_fade_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pattern = 8'h00;
    logic [3:0] brightness = 4'd0;
    logic       enable = 1'b0;
    logic [7:0] led_out;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;
    int hi_cnt [8];
    int tick_cnt;

    always #5 clk = ~clk;

    led_fade_pwm #(
        .PWM_BITS (4),
        .PRESCALE (2),
        .FADE_DIV (2),
        .DECAY    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pattern    (pattern),
        .brightness (brightness),
        .enable     (enable),
        .led_out    (led_out),
        .frame_tick (frame_tick)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts clocks after reset release until frame_tick is seen; the tick
    // edge itself is the following clock (clock 32).
    task automatic wait_first_tick(input string tag);
        int k;
        k = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                k = i + 1;
                break;
            end
        end
        check_eq(tag, k, 31);
    endtask

    // Called just after a frame_tick edge; samples the 32 clocks of the frame
    // and returns positioned just after the next frame_tick edge.
    task automatic count_frame(input int pat_at, input logic [7:0] pat_v,
                               input int en_at, input logic en_v);
        for (int b = 0; b < 8; b++) hi_cnt[b] = 0;
        tick_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == pat_at) pattern = pat_v;
            if (i == en_at) enable = en_v;
            @(negedge clk);
            for (int b = 0; b < 8; b++) hi_cnt[b] += int'(led_out[b]);
            if (frame_tick === 1'b1) tick_cnt++;
            if (i == en_at && !en_v) check_eq("en_drop_next_clk", int'(led_out), 0);
        end
    endtask

    int fade_exp [8] = '{24, 24, 16, 16, 8, 8, 0, 0};
    int others;

    initial begin
        pattern    = 8'h01;
        brightness = 4'd8;
        enable     = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_led_out", int'(led_out), 0);
        check_eq("rst_frame_tick", int'(frame_tick), 0);
        rst = 1'b0;
        wait_first_tick("first_tick_after_rst");
        @(negedge clk);

        // Level 8 loaded at tick 1; the brightness change mid-frame is ignored.
        brightness = 4'd15;
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("duty_lvl8_b0", hi_cnt[0], 16);
        others = 0;
        for (int b = 1; b < 8; b++) others += hi_cnt[b];
        check_eq("duty_lvl8_b7_1", others, 0);

        brightness = 4'd0;
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("duty_lvl15_b0", hi_cnt[0], 30);

        brightness = 4'd12;
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("duty_lvl0_b0", hi_cnt[0], 0);

        // Level 12 loaded at tick 4; decays land on even ticks.
        pattern = 8'h00;
        for (int f = 0; f < 8; f++) begin
            if (f == 7) begin
                pattern    = 8'h01;
                brightness = 4'd3;
            end
            count_frame(-1, 8'h00, -1, 1'b0);
            check_eq($sformatf("fade_frame%0d", f), hi_cnt[0], fade_exp[f]);
        end

        // Level 3 loaded; must saturate to 0 rather than wrap to 15.
        pattern = 8'h00;
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("lvl3_frame0", hi_cnt[0], 6);
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("lvl3_frame1", hi_cnt[0], 6);
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("lvl3_saturate", hi_cnt[0], 0);

        pattern    = 8'h01;
        brightness = 4'd10;
        count_frame(-1, 8'h00, -1, 1'b0);

        // Pattern moves 0x01 -> 0x80 at clock 10; no effect until next tick.
        count_frame(10, 8'h80, -1, 1'b0);
        check_eq("midchg_b0_same", hi_cnt[0], 20);
        check_eq("midchg_b7_same", hi_cnt[7], 0);
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("midchg_b0_hold", hi_cnt[0], 20);
        check_eq("midchg_b7_load", hi_cnt[7], 20);
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("midchg_b0_fade", hi_cnt[0], 12);
        check_eq("midchg_b7_keep", hi_cnt[7], 20);

        // Enable dropped at clock 8; levels keep decaying underneath.
        count_frame(-1, 8'h00, 8, 1'b0);
        check_eq("endrop_b0", hi_cnt[0], 8);
        check_eq("endrop_b7", hi_cnt[7], 8);
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("enoff_leds", hi_cnt[0] + hi_cnt[7], 0);
        check_eq("enoff_ticks", tick_cnt, 1);
        enable = 1'b1;
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("enon_b0_decayed", hi_cnt[0], 4);
        check_eq("enon_b7", hi_cnt[7], 20);

        // Asynchronous reset mid-frame while bit 7 is lit.
        repeat (5) @(negedge clk);
        check_eq("pre_rst_b7_on", int'(led_out[7]), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_led_out", int'(led_out), 0);
        check_eq("async_rst_frame_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_first_tick("tick_after_async_rst");
        @(negedge clk);
        count_frame(-1, 8'h00, -1, 1'b0);
        check_eq("post_rst_b7", hi_cnt[7], 20);
        check_eq("post_rst_b0", hi_cnt[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
